des_perm_engine: RTL and testbench

Parametrised, sequential DES bit-permutation engine producing either the Initial Permutation (IP) or its inverse (final permutation, IP⁻¹) of a 64-bit block. It trades area for latency by generating BITS_PER_CYCLE output bits per clock. Valid/ready handshakes sit on both sides. It sits between the block input buffer and the round datapath (IP), and between the round datapath and the output buffer (IP⁻¹).

---
 rtl/des_perm_engine.sv | 215 +++++++++++++++++++++
 tb/tb_des_perm_engine.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_perm_engine.sv
// -----------------------------------------------------------------------------
// des_perm_engine
//
// Sequential DES bit-permutation engine. Produces the Initial Permutation (IP)
// or, when built with DES_PERM_INV_EN, optionally its inverse (IP^-1) of a
// 64-bit block, BITS_PER_CYCLE output bits per clock.
//
// Configuration macro:
//   DES_PERM_INV_EN  - defined: IP^-1 table built, in_mode selects IP/IP^-1.
//                      undefined: only IP, in_mode ignored, ports unchanged.
//
// Parameters:
//   BITS_PER_CYCLE   - output bits produced per cycle (1,2,4,8,16,32,64).
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - in_data/in_mode valid
//   in_ready   - engine accepts a block this cycle (combinational)
//   in_data    - source block, DES bit 1 = in_data[63], bit 64 = in_data[0]
//   in_mode    - 0 = IP, 1 = IP^-1
//   out_valid  - out_data holds a completed block (registered)
//   out_ready  - downstream accepts out_data
//   out_data   - permuted block, same bit numbering (registered)
//   busy       - engine not idle (registered)
// -----------------------------------------------------------------------------
module des_perm_engine #(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  localparam int NCHUNK = 64 / BITS_PER_CYCLE;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  generate
    if ((BITS_PER_CYCLE != 1) && (BITS_PER_CYCLE != 2) && (BITS_PER_CYCLE != 4) &&
        (BITS_PER_CYCLE != 8) && (BITS_PER_CYCLE != 16) && (BITS_PER_CYCLE != 32) &&
        (BITS_PER_CYCLE != 64)) begin : g_bad_bits_per_cycle
      $error("des_perm_engine: BITS_PER_CYCLE must be 1,2,4,8,16,32 or 64");
    end
  endgenerate

  // Table entry i holds the DES source bit number for DES output bit i+1.
  localparam logic [6:0] IP_TAB [64] = '{
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
  };

  // DES bit n lives at vector index 64-n; the 6-bit cast folds that mapping.
  function automatic logic [63:0] ip_perm(input logic [63:0] src);
    logic [63:0] res;
    res = 64'd0;
    for (int i = 0; i < 64; i++) begin
      res[63-i] = src[6'(7'd64 - IP_TAB[i])];
    end
    return res;
  endfunction

`ifdef DES_PERM_INV_EN
  localparam logic [6:0] INV_TAB [64] = '{
    7'd40, 7'd8,  7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
    7'd39, 7'd7,  7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6,  7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
    7'd37, 7'd5,  7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4,  7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
    7'd35, 7'd3,  7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2,  7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
    7'd33, 7'd1,  7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
  };

  function automatic logic [63:0] inv_perm(input logic [63:0] src);
    logic [63:0] res;
    res = 64'd0;
    for (int i = 0; i < 64; i++) begin
      res[63-i] = src[6'(7'd64 - INV_TAB[i])];
    end
    return res;
  endfunction
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [63:0]     src_r;
  logic [63:0]     perm_s;
  logic            accept_s;

`ifdef DES_PERM_INV_EN
  logic            mode_r;

  // Permuted view of the latched block, table chosen by the latched mode.
  always_comb begin
    perm_s = 64'd0;
    if (mode_r) begin
      perm_s = inv_perm(src_r);
    end else begin
      perm_s = ip_perm(src_r);
    end
  end

  // Latch the mode with the block so it governs the whole permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r <= 1'b0;
    end else if (accept_s) begin
      mode_r <= in_mode;
    end
  end
`else
  logic            unused_mode_s;
  assign unused_mode_s = in_mode;

  // Only the forward table exists in this build.
  always_comb begin
    perm_s = ip_perm(src_r);
  end
`endif

  // Ready in IDLE, or in DONE when the finished block leaves this same cycle.
  always_comb begin
    case (state_r)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept_s = in_valid & in_ready;

  // Capture the source block on every accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_r <= 64'd0;
    end else if (accept_s) begin
      src_r <= in_data;
    end
  end

  // Control FSM: chunked write-out of the permuted block and output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      out_data  <= 64'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= RUN;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          for (int c = 0; c < NCHUNK; c++) begin
            if (cnt_r == CW'(c)) begin
              out_data[c*BITS_PER_CYCLE +: BITS_PER_CYCLE] <= perm_s[c*BITS_PER_CYCLE +: BITS_PER_CYCLE];
            end
          end
          // Hold cnt on the last chunk so it never wraps by overflow.
          if (cnt_r == LAST_CNT) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept_s) begin
              // Transfer and new accept in the same cycle.
              cnt_r   <= {CW{1'b0}};
              state_r <= RUN;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= {CW{1'b0}};
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_perm_engine.sv
// -----------------------------------------------------------------------------
// tb_des_perm_engine
//
// Directed self-checking bench for des_perm_engine. Main instance uses
// BITS_PER_CYCLE=8; two extra instances (1 and 64) are used for the
// walking-one latency sweep. Expected IP values come from a row/column
// formula of the IP structure, independent of the RTL lookup table.
// -----------------------------------------------------------------------------
module tb_des_perm_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, iv1, iv64;
  logic [63:0] in_data;
  logic        in_mode;
  logic        out_ready;

  logic        in_ready, out_valid, busy;
  logic [63:0] out_data;
  logic        rdy1, ov1, busy1;
  logic [63:0] od1;
  logic        rdy64, ov64, busy64;
  logic [63:0] od64;

  int checks = 0;
  int errors = 0;

  des_perm_engine #(.BITS_PER_CYCLE(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  des_perm_engine #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1),
    .in_data(in_data), .in_mode(in_mode), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .busy(busy1)
  );

  des_perm_engine #(.BITS_PER_CYCLE(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(rdy64),
    .in_data(in_data), .in_mode(in_mode), .out_valid(ov64),
    .out_ready(out_ready), .out_data(od64), .busy(busy64)
  );

  always #5 clk = ~clk;

  // IP row r, column c takes DES bit 8*(7-c) + (2r+2 for r<4, else 2(r-4)+1).
  function automatic logic [63:0] ref_ip(input logic [63:0] x);
    logic [63:0] y;
    int s;
    y = 64'd0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        s = 8*(7-c) + ((r < 4) ? (2*r + 2) : (2*(r-4) + 1));
        y[63 - (r*8 + c)] = x[64 - s];
      end
    end
    return y;
  endfunction

  // Inverse by scattering instead of gathering.
  function automatic logic [63:0] ref_inv(input logic [63:0] x);
    logic [63:0] y;
    int s;
    y = 64'd0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        s = 8*(7-c) + ((r < 4) ? (2*r + 2) : (2*(r-4) + 1));
        y[64 - s] = x[63 - (r*8 + c)];
      end
    end
    return y;
  endfunction

  function automatic logic [63:0] ref_mode(input logic [63:0] x, input logic m);
`ifdef DES_PERM_INV_EN
    return m ? ref_inv(x) : ref_ip(x);
`else
    return (m === 1'bx) ? 64'd0 : ref_ip(x);
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic m);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; iv1 = 1'b0; iv64 = 1'b0;
    in_data = 64'd0; in_mode = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL rst_out_data: got %h required 0", out_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ip;
    int n;
    send(64'h0123456789ABCDEF, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ip_busy: got %b required 1", busy); end
    wait_out(n);
    checks++; if (n != 8) begin errors++; $display("FAIL ip_latency: got %0d required 8", n); end
    checks++; if (out_data !== 64'hCC00CCFFF0AAF0AA) begin errors++; $display("FAIL ip_data: got %h required cc00ccfff0aaf0aa", out_data); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ip_idle: out_valid=%b busy=%b required 0 0", out_valid, busy); end
  endtask

  task automatic test_inv;
    int n;
    logic [63:0] exp_d;
`ifdef DES_PERM_INV_EN
    exp_d = 64'h0123456789ABCDEF;
`else
    exp_d = ref_ip(64'hCC00CCFFF0AAF0AA);
`endif
    send(64'hCC00CCFFF0AAF0AA, 1'b1);
    wait_out(n);
    checks++; if (out_data !== exp_d) begin errors++; $display("FAIL inv_data: got %h required %h", out_data, exp_d); end
    tick();
  endtask

  task automatic test_walk;
    int n1, n8, n64, c;
    logic [63:0] d, e, d1, d8, d64;
    for (int k = 0; k < 64; k++) begin
      d = 64'd1 << k;
      e = ref_ip(d);
      in_data = d; in_mode = 1'b0;
      in_valid = 1'b1; iv1 = 1'b1; iv64 = 1'b1;
      tick();
      in_valid = 1'b0; iv1 = 1'b0; iv64 = 1'b0;
      n1 = 0; n8 = 0; n64 = 0; c = 0;
      d1 = 64'd0; d8 = 64'd0; d64 = 64'd0;
      while ((n1 == 0 || n8 == 0 || n64 == 0) && c < 100) begin
        tick();
        c++;
        if (n1 == 0 && ov1) begin n1 = c; d1 = od1; end
        if (n8 == 0 && out_valid) begin n8 = c; d8 = out_data; end
        if (n64 == 0 && ov64) begin n64 = c; d64 = od64; end
      end
      checks++; if (n1 != 64) begin errors++; $display("FAIL walk_lat1 k=%0d: got %0d required 64", k, n1); end
      checks++; if (n8 != 8) begin errors++; $display("FAIL walk_lat8 k=%0d: got %0d required 8", k, n8); end
      checks++; if (n64 != 1) begin errors++; $display("FAIL walk_lat64 k=%0d: got %0d required 1", k, n64); end
      checks++; if (d1 !== e || $countones(d1) != 1) begin errors++; $display("FAIL walk_data1 k=%0d: got %h required %h", k, d1, e); end
      checks++; if (d8 !== e) begin errors++; $display("FAIL walk_data8 k=%0d: got %h required %h", k, d8, e); end
      checks++; if (d64 !== e) begin errors++; $display("FAIL walk_data64 k=%0d: got %h required %h", k, d64, e); end
      if (k == 0) begin
        checks++; if (d64 !== 64'h0000008000000000) begin errors++; $display("FAIL walk_k0: got %h required 0000008000000000", d64); end
      end
    end
    tick();
  endtask

  task automatic test_backpressure;
    int n;
    out_ready = 1'b0;
    send(64'h0123456789ABCDEF, 1'b0);
    wait_out(n);
    in_data = 64'hFEDCBA9876543210; in_mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d: got %b required 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== 64'hCC00CCFFF0AAF0AA) begin errors++; $display("FAIL bp_hold cyc=%0d: valid=%b data=%h required 1 cc00ccfff0aaf0aa", i, out_valid, out_data); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_reaccept: out_valid=%b busy=%b required 0 1", out_valid, busy); end
    wait_out(n);
    checks++; if (n != 8) begin errors++; $display("FAIL bp_latency: got %0d required 8", n); end
    checks++; if (out_data !== ref_ip(64'hFEDCBA9876543210)) begin errors++; $display("FAIL bp_data: got %h required %h", out_data, ref_ip(64'hFEDCBA9876543210)); end
    tick();
  endtask

  task automatic test_rst_midrun;
    int n;
    logic seen;
    send(64'h0123456789ABCDEF, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_flags: out_valid=%b busy=%b required 0 0", out_valid, busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b required 1", in_ready); end
    checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL midrst_out_data: got %h required 0", out_data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_out: got out_valid %b required 0", seen); end
    send(64'h0123456789ABCDEF, 1'b0);
    wait_out(n);
    checks++; if (out_data !== 64'hCC00CCFFF0AAF0AA) begin errors++; $display("FAIL midrst_data: got %h required cc00ccfff0aaf0aa", out_data); end
    tick();
  endtask

  task automatic test_random;
    localparam int NBLK = 1000;
    logic [63:0] exp_q [$];
    logic [63:0] e;
    int sent, recv, cyc;
    logic fin, fout;
    sent = 0; recv = 0; cyc = 0;
    while ((sent < NBLK || recv < NBLK) && cyc < 60000) begin
      in_valid  = (sent < NBLK) && ($urandom_range(3) != 0);
      in_data   = {$urandom, $urandom};
      in_mode   = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
      #1;
      fin  = in_valid & in_ready;
      fout = out_valid & out_ready;
      if (fin) begin
        exp_q.push_back(ref_mode(in_data, in_mode));
        sent++;
      end
      if (fout) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: unexpected block %h", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL rand_data blk=%0d: got %h required %h", recv, out_data, e);
          end
        end
        recv++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv != NBLK || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_count: got %0d blocks (%0d pending) required %0d", recv, exp_q.size(), NBLK);
    end
  endtask

  initial begin
    test_reset();
    test_ip();
    test_inv();
    test_walk();
    test_backpressure();
    test_rst_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
